// File: rtl/pp_dsp_pkg.sv
// Shared signed-DSP typedefs and width helpers for the polyphase decimators.
// Stage-1 entry kinds tag each pipeline slot as idle, partial MAC, frame-closing MAC or bypass.
package pp_dsp_pkg;

   localparam int SAMPLE_WIDTH = 16;
   localparam int COEFF_WIDTH  = 16;
   localparam int FIXED_ACC_WIDTH = 36;

   typedef logic signed [SAMPLE_WIDTH-1:0]    sample_t;
   typedef logic signed [COEFF_WIDTH-1:0]     coeff_t;
   typedef logic signed [FIXED_ACC_WIDTH-1:0] acc_t;

   typedef enum logic [1:0] {
      S1_IDLE = 2'd0,
      S1_MAC  = 2'd1,
      S1_LAST = 2'd2,
      S1_BYP  = 2'd3
   } s1_kind_e;

   // Full-precision width for n products of d-bit by c-bit signed operands.
   function automatic int acc_width(input int d, input int c, input int n);
      return d + c + $clog2(n);
   endfunction

   function automatic int phase_width(input int m);
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/pp_decimator_m_if.sv
// Sample/control bundle between the sample source and the decimator; no backpressure,
// valid_in may be high every cycle and valid_out is a single-cycle strobe.
interface pp_decimator_m_if
   import pp_dsp_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int ACC_WIDTH   = acc_width(16, 16, 12),
   parameter int PHASE_WIDTH = 2
);
   logic                          flush;
   logic                          bypass;
   logic signed [DATA_WIDTH-1:0]  data_in;
   logic                          valid_in;
   logic signed [ACC_WIDTH-1:0]   data_out;
   logic                          valid_out;
   logic [PHASE_WIDTH-1:0]        phase;

   modport master (
      output flush, bypass, data_in, valid_in,
      input  data_out, valid_out, phase
   );

   modport slave (
      input  flush, bypass, data_in, valid_in,
      output data_out, valid_out, phase
   );
endinterface

// File: rtl/pp_branch_mac.sv
// One polyphase branch: L-deep sample line with enable and a combinational dot product.
// The sum reflects the line as it will be after the current shift, so the caller can register it in the same cycle.
module pp_branch_mac
   import pp_dsp_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int COEFF_WIDTH = 16,
   parameter int TAPS        = 3,
   parameter int SUM_WIDTH   = 36
) (
   input  logic                                   clk,
   input  logic                                   arst_n,
   input  logic                                   clr,
   input  logic                                   shift_en,
   input  logic signed [DATA_WIDTH-1:0]           sample,
   input  logic signed [TAPS-1:0][COEFF_WIDTH-1:0] coeffs,
   output logic signed [SUM_WIDTH-1:0]            sum
);
   localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;
   localparam int LEAVES     = 1 << $clog2(TAPS);

   logic signed [DATA_WIDTH-1:0] win [TAPS];
   logic signed [PROD_WIDTH-1:0] prod;
   logic signed [SUM_WIDTH-1:0]  node [2*LEAVES-1];

   // Tap 0 is the incoming sample itself, so only the L-1 older samples need storage.
   assign win[0] = sample;

   if (TAPS > 1) begin : g_line
      logic signed [DATA_WIDTH-1:0] line [TAPS-1];

      always_ff @(posedge clk or negedge arst_n) begin
         if (!arst_n) begin
            for (int k = 0; k < TAPS-1; k++) line[k] <= '0;
         end else if (clr) begin
            for (int k = 0; k < TAPS-1; k++) line[k] <= '0;
         end else if (shift_en) begin
            line[0] <= sample;
            for (int k = 1; k < TAPS-1; k++) line[k] <= line[k-1];
         end
      end

      for (genvar k = 1; k < TAPS; k++) begin : g_win
         assign win[k] = line[k-1];
      end
   end

   // Heap-ordered binary adder tree; leaves beyond TAPS stay zero.
   always_comb begin
      prod = '0;
      for (int i = 0; i < 2*LEAVES-1; i++) node[i] = '0;
      for (int k = 0; k < TAPS; k++) begin
         prod = $signed({{COEFF_WIDTH{win[k][DATA_WIDTH-1]}}, win[k]}) *
                $signed({{DATA_WIDTH{coeffs[k][COEFF_WIDTH-1]}}, coeffs[k]});
         node[LEAVES-1+k] = {{(SUM_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
      end
      for (int i = LEAVES-2; i >= 0; i--) node[i] = node[2*i+1] + node[2*i+2];
   end

   assign sum = node[0];

endmodule

// File: rtl/pp_decimator_m.sv
// Polyphase FIR decimator by M with flush and bypass; 2-cycle latency from the frame-closing sample.
// No backpressure: accepts a sample every cycle and emits one full-precision output per M samples.
module pp_decimator_m
   import pp_dsp_pkg::*;
#(
   parameter int DATA_WIDTH     = 16,
   parameter int COEFF_WIDTH    = 16,
   parameter int DECIM_FACTOR   = 4,
   parameter int TAPS_PER_PHASE = 3
) (
   input  logic                                                         clk,
   input  logic                                                         arst_n,
   input  logic signed [DECIM_FACTOR*TAPS_PER_PHASE-1:0][COEFF_WIDTH-1:0] coeffs,
   pp_decimator_m_if.slave                                              bus
);
   localparam int N_COEFFS  = DECIM_FACTOR * TAPS_PER_PHASE;
   localparam int ACC_WIDTH = acc_width(DATA_WIDTH, COEFF_WIDTH, N_COEFFS);
   localparam int PH_WIDTH  = phase_width(DECIM_FACTOR);
   localparam logic [PH_WIDTH-1:0] PH_LAST = PH_WIDTH'(DECIM_FACTOR - 1);

   logic [PH_WIDTH-1:0]         ph;
   logic                        accept;
   logic                        last;
   logic signed [ACC_WIDTH-1:0] br_sum [DECIM_FACTOR];
   logic signed [ACC_WIDTH-1:0] sel_sum;
   logic signed [ACC_WIDTH-1:0] byp_val;
   s1_kind_e                    s1_kind;
   logic signed [ACC_WIDTH-1:0] s1_sum;
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] dout;
   logic                        vout;

   assign accept = bus.valid_in & ~bus.flush & ~bus.bypass;
   assign last   = (ph == PH_LAST);

   // Branch b sees samples with phase b; its k-th newest sample meets h[(M-1-b)+k*M].
   for (genvar b = 0; b < DECIM_FACTOR; b++) begin : g_branch
      logic signed [TAPS_PER_PHASE-1:0][COEFF_WIDTH-1:0] bc;

      for (genvar k = 0; k < TAPS_PER_PHASE; k++) begin : g_coef
         assign bc[k] = coeffs[(DECIM_FACTOR-1-b) + k*DECIM_FACTOR];
      end

      pp_branch_mac #(
         .DATA_WIDTH  (DATA_WIDTH),
         .COEFF_WIDTH (COEFF_WIDTH),
         .TAPS        (TAPS_PER_PHASE),
         .SUM_WIDTH   (ACC_WIDTH)
      ) u_mac (
         .clk      (clk),
         .arst_n   (arst_n),
         .clr      (bus.flush),
         .shift_en (accept && (ph == PH_WIDTH'(b))),
         .sample   (bus.data_in),
         .coeffs   (bc),
         .sum      (br_sum[b])
      );
   end

   always_comb begin
      sel_sum = '0;
      for (int b = 0; b < DECIM_FACTOR; b++) begin
         if (ph == PH_WIDTH'(b)) sel_sum = br_sum[b];
      end
   end

   // Bypass presents the sample at the same binary point as a unity-gain filter output.
   assign byp_val = {{(ACC_WIDTH-DATA_WIDTH){bus.data_in[DATA_WIDTH-1]}}, bus.data_in} << (COEFF_WIDTH-1);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         ph <= '0;
      end else if (bus.flush || bus.bypass) begin
         ph <= '0;
      end else if (accept) begin
         ph <= last ? '0 : ph + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         s1_kind <= S1_IDLE;
         s1_sum  <= '0;
      end else if (bus.flush) begin
         s1_kind <= S1_IDLE;
         s1_sum  <= '0;
      end else if (bus.bypass) begin
         s1_kind <= bus.valid_in ? S1_BYP : S1_IDLE;
         s1_sum  <= byp_val;
      end else begin
         s1_kind <= !bus.valid_in ? S1_IDLE : (last ? S1_LAST : S1_MAC);
         s1_sum  <= sel_sum;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         acc  <= '0;
         dout <= '0;
         vout <= 1'b0;
      end else if (bus.flush) begin
         acc  <= '0;
         vout <= 1'b0;
      end else begin
         vout <= 1'b0;
         case (s1_kind)
            S1_BYP: begin
               dout <= s1_sum;
               vout <= 1'b1;
            end
            S1_LAST: begin
               dout <= acc + s1_sum;
               vout <= 1'b1;
               acc  <= '0;
            end
            S1_MAC:  acc <= acc + s1_sum;
            default: ;
         endcase
         // Entering or holding bypass abandons any partial frame.
         if (bus.bypass) acc <= '0;
      end
   end

   assign bus.data_out  = dout;
   assign bus.valid_out = vout;
   assign bus.phase     = ph;

endmodule

// File: tb/tb_pp_decimator_m.sv
// Randomized scoreboard bench for pp_decimator_m against a direct-convolution reference.
module tb_pp_decimator_m;
   import pp_dsp_pkg::*;

   localparam int D  = 16;
   localparam int C  = 16;
   localparam int M  = 4;
   localparam int L  = 3;
   localparam int N  = M * L;
   localparam int A  = acc_width(D, C, N);
   localparam int PW = phase_width(M);

   typedef struct {
      longint val;
      int     due;
   } exp_t;

   logic clk = 1'b0;
   logic arst_n = 1'b0;
   logic signed [N-1:0][C-1:0] coeffs = '0;

   pp_decimator_m_if #(.DATA_WIDTH(D), .ACC_WIDTH(A), .PHASE_WIDTH(PW)) bus ();

   pp_decimator_m #(
      .DATA_WIDTH     (D),
      .COEFF_WIDTH    (C),
      .DECIM_FACTOR   (M),
      .TAPS_PER_PHASE (L)
   ) dut (
      .clk    (clk),
      .arst_n (arst_n),
      .coeffs (coeffs),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int     n_cmp = 0;
   int     n_bad = 0;
   exp_t   sbq[$];
   longint hist[$];
   longint h[N];
   int     mphase = 0;

   task automatic check(input string nm, input longint act, input longint req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // y[j] = sum_i h[i] * x[j-i], samples before the start of history are zero.
   function automatic longint conv(input int j);
      longint s = 0;
      for (int i = 0; i < N; i++) begin
         if (j - i >= 0) s += h[i] * hist[j-i];
      end
      return s;
   endfunction

   task automatic push_exp(input longint v, input int due);
      exp_t e;
      e.val = v;
      e.due = due;
      sbq.push_back(e);
   endtask

   task automatic drive(input bit v, input logic signed [D-1:0] x, input bit fl, input bit bp);
      int k;
      @(negedge clk);
      check("phase", longint'(bus.phase), longint'(mphase));
      bus.valid_in = v;
      bus.data_in  = x;
      bus.flush    = fl;
      bus.bypass   = bp;
      k = cyc;
      if (fl) begin
         hist.delete();
         mphase = 0;
         while (sbq.size() > 0 && sbq[sbq.size()-1].due > k) void'(sbq.pop_back());
      end else if (bp) begin
         mphase = 0;
         if (v) push_exp(longint'(x) <<< (C-1), k + 2);
      end else if (v) begin
         hist.push_back(longint'(x));
         if (mphase == M-1) push_exp(conv(hist.size() - 1), k + 2);
         mphase = (mphase + 1) % M;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 16'($urandom()), 1'b0, 1'b0);
   endtask

   task automatic load_coeffs();
      for (int i = 0; i < N; i++) coeffs[i] = h[i][C-1:0];
      drive(1'b0, 16'sd0, 1'b1, 1'b0);
   endtask

   task automatic run_random(input int nsamp);
      for (int s = 0; s < nsamp; s++) begin
         idle($urandom_range(0, 3));
         drive(1'b1, 16'($urandom()), 1'b0, 1'b0);
      end
   endtask

   // Monitor: every valid_out must match the oldest expectation, value and cycle.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (arst_n) begin
            if (bus.valid_out) begin
               if (sbq.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_out: got valid_out with %0d, expected none (cycle %0d)",
                           $signed(bus.data_out), cyc);
               end else begin
                  e = sbq.pop_front();
                  check("out_val", $signed(bus.data_out), e.val);
                  check("out_cycle", longint'(cyc), longint'(e.due));
               end
            end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
               e = sbq.pop_front();
               check("missing_out", 0, 1);
            end
         end
      end
   end

   initial begin
      bus.valid_in = 1'b0;
      bus.data_in  = '0;
      bus.flush    = 1'b0;
      bus.bypass   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_data_out", $signed(bus.data_out), 0);
      check("rst_valid_out", longint'(bus.valid_out), 0);
      check("rst_phase", longint'(bus.phase), 0);
      arst_n = 1'b1;

      // Impulse with h[i] = i+1.
      for (int i = 0; i < N; i++) h[i] = i + 1;
      load_coeffs();
      drive(1'b1, 16'sd1, 1'b0, 1'b0);
      repeat (19) drive(1'b1, 16'sd0, 1'b0, 1'b0);
      idle(4);

      // Constant input.
      drive(1'b0, 16'sd0, 1'b1, 1'b0);
      repeat (16) drive(1'b1, 16'sd1, 1'b0, 1'b0);
      idle(4);

      // Worst-case magnitude.
      for (int i = 0; i < N; i++) h[i] = -32768;
      load_coeffs();
      repeat (16) drive(1'b1, 16'sh8000, 1'b0, 1'b0);
      idle(4);

      // Random coefficients and data with idle gaps, ending on a frame boundary.
      for (int i = 0; i < N; i++) h[i] = longint'($signed(16'($urandom())));
      load_coeffs();
      run_random(400);

      // Bypass, then resume filtering on the frozen delay lines from phase 0.
      repeat (6) drive(1'b1, 16'sh1234, 1'b0, 1'b1);
      repeat (6) drive(1'b1, 16'sh8000, 1'b0, 1'b1);
      run_random(40);
      idle(4);

      // Flush after two samples of a frame (flush also carries a discarded sample).
      for (int i = 0; i < N; i++) h[i] = i + 1;
      load_coeffs();
      repeat (6) drive(1'b1, 16'($urandom()), 1'b0, 1'b0);
      drive(1'b1, 16'sh7fff, 1'b1, 1'b0);
      drive(1'b1, 16'sd1, 1'b0, 1'b0);
      repeat (11) drive(1'b1, 16'sd0, 1'b0, 1'b0);

      // Flush right after a frame closes drops its in-flight output.
      repeat (4) drive(1'b1, 16'($urandom()), 1'b0, 1'b0);
      drive(1'b0, 16'sd0, 1'b1, 1'b0);
      idle(3);

      // Bypass rising mid-frame discards the partial frame.
      repeat (2) drive(1'b1, 16'($urandom()), 1'b0, 1'b0);
      repeat (3) drive(1'b1, 16'($urandom()), 1'b0, 1'b1);
      idle(3);
      drive(1'b0, 16'sd0, 1'b1, 1'b0);
      run_random(24);
      idle(4);

      // Asynchronous reset while a frame output is in flight.
      repeat (4) drive(1'b1, 16'($urandom()), 1'b0, 1'b0);
      @(posedge clk);
      #2;
      arst_n = 1'b0;
      bus.valid_in = 1'b0;
      sbq.delete();
      hist.delete();
      mphase = 0;
      #1;
      check("arst_data_out", $signed(bus.data_out), 0);
      check("arst_valid_out", longint'(bus.valid_out), 0);
      check("arst_phase", longint'(bus.phase), 0);
      @(negedge clk);
      arst_n = 1'b1;
      drive(1'b1, 16'sd1, 1'b0, 1'b0);
      repeat (11) drive(1'b1, 16'sd0, 1'b0, 1'b0);
      idle(6);

      check("drain", longint'(sbq.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
